// File: rtl/rpn_stack_calculator_if.sv
// Command channel for the RPN stack calculator.
// Carries cmd_valid/cmd_ready handshake, cmd_op and cmd_data.
interface rpn_stack_calculator_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_op;
  logic [DATA_WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/rpn_stack_calculator.sv
// RPN stack calculator: PUSH/ADD/SUB/AND/OR/XOR/DUP/CLEAR on a LIFO.
// Ports: clk, rst_n, cmd (if slave), top, depth, done, carry, err_*.
module rpn_stack_calculator #(
  parameter int DATA_WIDTH  = 8,
  parameter int STACK_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  rpn_stack_calculator_if.slave          cmd,
  output logic [DATA_WIDTH-1:0]          top,
  output logic [$clog2(STACK_DEPTH):0]   depth,
  output logic                           done,
  output logic                           carry,
  output logic                           err_underflow,
  output logic                           err_overflow
);

  localparam int AW = $clog2(STACK_DEPTH);

  localparam logic [2:0] OP_PUSH  = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_XOR   = 3'b101;
  localparam logic [2:0] OP_DUP   = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  localparam logic [AW:0]   SP_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   SP_TWO  = (AW+1)'(2);
  localparam logic [AW:0]   SP_FULL = (AW+1)'(STACK_DEPTH);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);

  typedef enum logic [2:0] {
    IDLE,
    POP_B,
    POP_A,
    EXEC,
    WRITE
  } state_t;

  state_t                state_q;
  state_t                state_d;

  logic [DATA_WIDTH-1:0] mem [STACK_DEPTH];
  logic [AW:0]           sp_q;
  logic [AW-1:0]         rd_idx;
  logic [DATA_WIDTH-1:0] rd_data;

  logic [2:0]            op_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] r_q;
  logic                  done_q;

  logic                  accept;
  logic                  empty;
  logic                  full;
  logic                  is_unf;
  logic                  is_ovf;
  logic                  is_clr;

  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] alu_r;
  logic                  alu_c;

  // sp points at the next free slot; top lives one below it.
  assign rd_idx  = sp_q[AW-1:0] - IDX_ONE;
  assign rd_data = mem[rd_idx];
  assign empty   = (sp_q == '0);
  assign full    = (sp_q == SP_FULL);

  assign cmd.cmd_ready = (state_q == IDLE);
  assign accept        = cmd.cmd_valid && (state_q == IDLE);

  assign top   = empty ? '0 : rd_data;
  assign depth = sp_q;
  // Error/CLEAR completions stay in IDLE, so they use a registered pulse.
  assign done  = (state_q == WRITE) || done_q;

  assign sum = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    alu_r = b_q;
    alu_c = carry;
    case (op_q)
      OP_ADD: begin
        alu_r = sum[DATA_WIDTH-1:0];
        alu_c = sum[DATA_WIDTH];
      end
      OP_SUB: begin
        alu_r = a_q - b_q;
        alu_c = (a_q < b_q);
      end
      OP_AND: alu_r = a_q & b_q;
      OP_OR:  alu_r = a_q | b_q;
      OP_XOR: alu_r = a_q ^ b_q;
      default: begin
        alu_r = b_q;
        alu_c = carry;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    is_unf  = 1'b0;
    is_ovf  = 1'b0;
    is_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (cmd.cmd_op)
            OP_PUSH: begin
              if (full) is_ovf  = 1'b1;
              else      state_d = WRITE;
            end
            OP_DUP: begin
              if (empty)     is_unf  = 1'b1;
              else if (full) is_ovf  = 1'b1;
              else           state_d = POP_B;
            end
            OP_CLEAR: is_clr = 1'b1;
            default: begin
              if (sp_q < SP_TWO) is_unf  = 1'b1;
              else               state_d = POP_B;
            end
          endcase
        end
      end
      POP_B:   state_d = (op_q == OP_DUP) ? WRITE : POP_A;
      POP_A:   state_d = EXEC;
      EXEC:    state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sp_q          <= '0;
      op_q          <= OP_PUSH;
      a_q           <= '0;
      b_q           <= '0;
      r_q           <= '0;
      done_q        <= 1'b0;
      carry         <= 1'b0;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= is_unf || is_ovf || is_clr;
      if (accept) begin
        op_q <= cmd.cmd_op;
        r_q  <= cmd.cmd_data;
      end
      if (is_unf) err_underflow <= 1'b1;
      if (is_ovf) err_overflow  <= 1'b1;
      if (is_clr) begin
        sp_q          <= '0;
        carry         <= 1'b0;
        err_underflow <= 1'b0;
        err_overflow  <= 1'b0;
      end
      case (state_q)
        POP_B: begin
          b_q <= rd_data;
          // DUP peeks only; the copy is pushed back in WRITE.
          if (op_q == OP_DUP) r_q  <= rd_data;
          else                sp_q <= sp_q - SP_ONE;
        end
        POP_A: begin
          a_q  <= rd_data;
          sp_q <= sp_q - SP_ONE;
        end
        EXEC: begin
          r_q   <= alu_r;
          carry <= alu_c;
        end
        WRITE: sp_q <= sp_q + SP_ONE;
        default: ;
      endcase
    end
  end

  // Storage has no reset; depth=0 makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (state_q == WRITE) mem[sp_q[AW-1:0]] <= r_q;
  end

endmodule

// File: tb/tb_rpn_stack_calculator.sv
// Self-checking bench for rpn_stack_calculator (DATA_WIDTH=8, depth 16).
// Table-driven command vectors plus overflow, busy and reset sequences.
module tb_rpn_stack_calculator;

  localparam logic [2:0] P_PUSH  = 3'b000;
  localparam logic [2:0] P_ADD   = 3'b001;
  localparam logic [2:0] P_SUB   = 3'b010;
  localparam logic [2:0] P_AND   = 3'b011;
  localparam logic [2:0] P_OR    = 3'b100;
  localparam logic [2:0] P_XOR   = 3'b101;
  localparam logic [2:0] P_DUP   = 3'b110;
  localparam logic [2:0] P_CLEAR = 3'b111;

  logic       clk;
  logic       rst_n;
  logic [7:0] top;
  logic [4:0] depth;
  logic       done;
  logic       carry;
  logic       err_underflow;
  logic       err_overflow;

  int errors;
  int checks;

  rpn_stack_calculator_if #(.DATA_WIDTH(8)) cif ();

  rpn_stack_calculator #(
    .DATA_WIDTH(8),
    .STACK_DEPTH(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd(cif.slave),
    .top(top),
    .depth(depth),
    .done(done),
    .carry(carry),
    .err_underflow(err_underflow),
    .err_overflow(err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
    int         lat;
    logic [7:0] top;
    logic [4:0] depth;
    logic       carry;
    logic       unf;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one command from IDLE, return cycles from accept to done.
  task automatic send(input logic [2:0] op, input logic [7:0] data,
                      output int lat);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_data  = data;
    @(posedge clk);
    #1;
    cif.cmd_valid = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    @(posedge clk);
    #1;
  endtask

  int lat;
  int dcnt;

  initial begin
    errors        = 0;
    checks        = 0;
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 3'b000;
    cif.cmd_data  = 8'h00;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_depth", int'(depth), 0);
    chk("rst_top", int'(top), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_carry", int'(carry), 0);
    chk("rst_unf", int'(err_underflow), 0);
    chk("rst_ovf", int'(err_overflow), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready", int'(cif.cmd_ready), 1);

    vecs.push_back('{P_PUSH,  8'h05, 1, 8'h05, 5'd1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{P_PUSH,  8'h03, 1, 8'h03, 5'd2, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{P_SUB,   8'hAA, 4, 8'h02, 5'd1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{P_CLEAR, 8'h00, 1, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{P_PUSH,  8'h03, 1, 8'h03, 5'd1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{P_PUSH,  8'h05, 1, 8'h05, 5'd2, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{P_SUB,   8'h00, 4, 8'hFE, 5'd1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{P_CLEAR, 8'h00, 1, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{P_PUSH,  8'hFF, 1, 8'hFF, 5'd1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{P_PUSH,  8'h01, 1, 8'h01, 5'd2, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{P_ADD,   8'h00, 4, 8'h00, 5'd1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{P_PUSH,  8'h0F, 1, 8'h0F, 5'd2, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{P_AND,   8'h00, 4, 8'h00, 5'd1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{P_PUSH,  8'h3C, 1, 8'h3C, 5'd2, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{P_OR,    8'h00, 4, 8'h3C, 5'd1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{P_PUSH,  8'h5A, 1, 8'h5A, 5'd2, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{P_XOR,   8'h00, 4, 8'h66, 5'd1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{P_DUP,   8'h00, 2, 8'h66, 5'd2, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{P_ADD,   8'h00, 4, 8'hCC, 5'd1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{P_CLEAR, 8'h00, 1, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{P_ADD,   8'h00, 1, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{P_CLEAR, 8'h00, 1, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{P_PUSH,  8'h09, 1, 8'h09, 5'd1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{P_SUB,   8'h00, 1, 8'h09, 5'd1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{P_DUP,   8'h00, 2, 8'h09, 5'd2, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{P_CLEAR, 8'h00, 1, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0});

    foreach (vecs[i]) begin
      send(vecs[i].op, vecs[i].data, lat);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_top", i), int'(top), int'(vecs[i].top));
      chk($sformatf("v%0d_depth", i), int'(depth), int'(vecs[i].depth));
      chk($sformatf("v%0d_carry", i), int'(carry), int'(vecs[i].carry));
      chk($sformatf("v%0d_unf", i), int'(err_underflow), int'(vecs[i].unf));
      chk($sformatf("v%0d_ovf", i), int'(err_overflow), int'(vecs[i].ovf));
      chk($sformatf("v%0d_idle_done", i), int'(done), 0);
    end

    // Fill to capacity, then PUSH and DUP must both overflow.
    for (int i = 1; i <= 16; i++) send(P_PUSH, 8'(i), lat);
    chk("full_depth", int'(depth), 16);
    chk("full_top", int'(top), 16);
    chk("full_ovf0", int'(err_overflow), 0);
    send(P_PUSH, 8'h07, lat);
    chk("ovf_push_lat", lat, 1);
    chk("ovf_push_flag", int'(err_overflow), 1);
    chk("ovf_push_depth", int'(depth), 16);
    chk("ovf_push_top", int'(top), 16);
    send(P_DUP, 8'h00, lat);
    chk("ovf_dup_lat", lat, 1);
    chk("ovf_dup_depth", int'(depth), 16);
    chk("ovf_dup_top", int'(top), 16);
    chk("ovf_dup_unf", int'(err_underflow), 0);
    send(P_SUB, 8'h00, lat);
    chk("full_sub_lat", lat, 4);
    chk("full_sub_top", int'(top), 8'hFF);
    chk("full_sub_carry", int'(carry), 1);
    chk("full_sub_depth", int'(depth), 15);
    send(P_CLEAR, 8'h00, lat);
    chk("clr_ovf", int'(err_overflow), 0);
    chk("clr_carry", int'(carry), 0);

    // A PUSH presented while busy must be dropped, not queued.
    send(P_PUSH, 8'h10, lat);
    send(P_PUSH, 8'h04, lat);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = P_SUB;
    @(posedge clk);
    #1;
    cif.cmd_op    = P_PUSH;
    cif.cmd_data  = 8'h77;
    chk("busy_ready", int'(cif.cmd_ready), 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    cif.cmd_valid = 1'b0;
    lat = 3;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("busy_lat", lat, 4);
    @(posedge clk);
    #1;
    repeat (2) @(posedge clk);
    #1;
    chk("busy_depth", int'(depth), 1);
    chk("busy_top", int'(top), 8'h0C);

    // Reset during POP_A of an XOR abandons it.
    send(P_PUSH, 8'h01, lat);
    send(P_PUSH, 8'h02, lat);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = P_XOR;
    @(posedge clk);
    #1;
    cif.cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_depth", int'(depth), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_top", int'(top), 0);
    dcnt = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    rst_n = 1'b1;
    chk("mid_rst_ready", int'(cif.cmd_ready), 1);
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    chk("mid_rst_no_done", dcnt, 0);
    chk("mid_rst_depth2", int'(depth), 0);
    send(P_PUSH, 8'h42, lat);
    chk("post_rst_lat", lat, 1);
    chk("post_rst_top", int'(top), 8'h42);
    chk("post_rst_depth", int'(depth), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
